// File: rtl/jh_adc_scan_scheduler_pkg.sv
// Shared definitions for the ADC-side blocks: scan FSM encoding, channel codes, mask helpers.
package jh_adc_scan_scheduler_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] CH0_CODE_DEF = 4'd0;
    localparam logic [CODE_W-1:0] CH1_CODE_DEF = 4'd2;
    localparam logic [CODE_W-1:0] CH2_CODE_DEF = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CONV,
        ST_CAPT,
        ST_NEXT,
        ST_WAIT
    } scan_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [1:0] lowest_ch(input logic [2:0] mask);
        if (mask[0]) begin
            lowest_ch = 2'd0;
        end else if (mask[1]) begin
            lowest_ch = 2'd1;
        end else if (mask[2]) begin
            lowest_ch = 2'd2;
        end else begin
            lowest_ch = 2'd0;
        end
    endfunction

    // Mask of the channel positions strictly above ch.
    function automatic logic [2:0] mask_above(input logic [1:0] ch);
        case (ch)
            2'd0:    mask_above = 3'b110;
            2'd1:    mask_above = 3'b100;
            default: mask_above = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/jh_sync_fall_detect.sv
// Brings the asynchronous ADC busy flag into clk and flags its falling edge.
module jh_sync_fall_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic hist;

    // Two synchronizer stages plus one history stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            hist <= sync;
        end
    end

    assign fall_c = hist & ~sync;

endmodule

// File: rtl/jh_adc_scan_scheduler.sv
// Scan scheduler for the shared ADC: sequences enabled channels, oversamples, publishes averages.
module jh_adc_scan_scheduler
    import jh_adc_scan_scheduler_pkg::*;
#(
    parameter logic [CODE_W-1:0] CH0_CODE    = CH0_CODE_DEF,
    parameter logic [CODE_W-1:0] CH1_CODE    = CH1_CODE_DEF,
    parameter logic [CODE_W-1:0] CH2_CODE    = CH2_CODE_DEF,
    parameter int unsigned       OSR_LOG2    = 2,
    parameter int unsigned       TIMEOUT     = 1000,
    parameter int unsigned       SCAN_PERIOD = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2:0]        ch_mask,
    input  logic              adc_flag,
    input  logic [DATA_W-1:0] adc_data,
    output logic [CODE_W-1:0] adc_ch,
    output logic              adc_start,
    output logic [DATA_W-1:0] temperature1,
    output logic [DATA_W-1:0] temperature2,
    output logic [DATA_W-1:0] foot,
    output logic              result_valid,
    output logic [1:0]        result_ch,
    output logic [2:0]        timeout_err
);

    localparam int unsigned ACC_W       = DATA_W + OSR_LOG2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LAST_SAMPLE = (1 << OSR_LOG2) - 1;
    localparam int unsigned TMO_W       = $clog2(TIMEOUT + 1);
    localparam int unsigned PER_W       = $clog2(SCAN_PERIOD + 1);

    scan_state_e                    state_q, state_d;
    logic [1:0]                     ch_q, ch_d;
    logic [ACC_W-1:0]               acc_q, acc_d, sum_c;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    logic [PER_W-1:0]               per_q, per_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  res_q, res_d;
    logic [CODE_W-1:0]              adc_ch_d;
    logic                           adc_start_d;
    logic                           valid_d;
    logic [1:0]                     res_ch_d;
    logic [2:0]                     terr_d;
    logic [2:0]                     above_c;
    logic [1:0]                     first_c;
    logic                           fall_c;

    function automatic logic [CODE_W-1:0] ch_code(input logic [1:0] ch);
        case (ch)
            2'd0:    ch_code = CH0_CODE;
            2'd1:    ch_code = CH1_CODE;
            default: ch_code = CH2_CODE;
        endcase
    endfunction

    jh_sync_fall_detect u_flag_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (adc_flag),
        .fall_c   (fall_c)
    );

    assign temperature1 = res_q[0];
    assign temperature2 = res_q[1];
    assign foot         = res_q[2];

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        per_d       = per_q;
        res_d       = res_q;
        adc_ch_d    = adc_ch;
        adc_start_d = 1'b0;
        valid_d     = 1'b0;
        res_ch_d    = result_ch;
        terr_d      = timeout_err;
        sum_c       = acc_q + ACC_W'(adc_data);
        above_c     = ch_mask & mask_above(ch_q);
        first_c     = lowest_ch(ch_mask);

        case (state_q)
            ST_IDLE: begin
                if (enable && (ch_mask != 3'b000)) begin
                    ch_d     = first_c;
                    adc_ch_d = ch_code(first_c);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_CONV;
            end
            ST_CONV: begin
                // A fall in the same cycle as the timeout still counts as a capture
                if (fall_c) begin
                    state_d = ST_CAPT;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    terr_d[ch_q] = 1'b1;
                    acc_d        = '0;
                    cnt_d        = '0;
                    state_d      = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CAPT: begin
                if (cnt_q < CNT_W'(LAST_SAMPLE)) begin
                    acc_d   = sum_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_START;
                end else begin
                    res_d[ch_q] = DATA_W'(sum_c >> OSR_LOG2);
                    valid_d     = 1'b1;
                    res_ch_d    = ch_q;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (above_c != 3'b000) begin
                    ch_d     = lowest_ch(above_c);
                    adc_ch_d = ch_code(lowest_ch(above_c));
                    state_d  = ST_START;
                end else begin
                    ch_d     = first_c;
                    adc_ch_d = ch_code(first_c);
                    per_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (per_q == PER_W'(SCAN_PERIOD - 1)) begin
                    if (ch_mask != 3'b000) begin
                        ch_d     = first_c;
                        adc_ch_d = ch_code(first_c);
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        adc_start_d = (state_d == ST_START);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= 2'd0;
            acc_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            per_q        <= '0;
            res_q        <= '0;
            adc_ch       <= '0;
            adc_start    <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= 2'd0;
            timeout_err  <= 3'b000;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            per_q        <= per_d;
            res_q        <= res_d;
            adc_ch       <= adc_ch_d;
            adc_start    <= adc_start_d;
            result_valid <= valid_d;
            result_ch    <= res_ch_d;
            timeout_err  <= terr_d;
        end
    end

endmodule

// File: tb/tb_jh_adc_scan_scheduler.sv
// Self-checking bench for jh_adc_scan_scheduler with an ADC behavioural model and result scoreboard.
`timescale 1ns/1ps
module tb_jh_adc_scan_scheduler;
    import jh_adc_scan_scheduler_pkg::*;

    localparam int unsigned OSR   = 2;
    localparam int unsigned NSAMP = 1 << OSR;
    localparam int unsigned TMO   = 40;
    localparam int unsigned SP    = 30;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [2:0]  ch_mask;
    logic        adc_flag;
    logic [15:0] adc_data;
    logic [3:0]  adc_ch;
    logic        adc_start;
    logic [15:0] temperature1;
    logic [15:0] temperature2;
    logic [15:0] foot;
    logic        result_valid;
    logic [1:0]  result_ch;
    logic [2:0]  timeout_err;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        logic [2:0]  mask;
        logic [15:0] b0, b1, b2, st;
        logic [15:0] e0, e1, e2;
    } vec_t;

    exp_t        sb_q[$];
    logic [3:0]  code_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] base[3];
    logic [15:0] step;
    logic        hang[3];
    int          glitch_req = 0;
    int          glitch_done = 0;
    vec_t        vt[5];

    jh_adc_scan_scheduler #(
        .OSR_LOG2    (OSR),
        .TIMEOUT     (TMO),
        .SCAN_PERIOD (SP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .adc_flag     (adc_flag),
        .adc_data     (adc_data),
        .adc_ch       (adc_ch),
        .adc_start    (adc_start),
        .temperature1 (temperature1),
        .temperature2 (temperature2),
        .foot         (foot),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int code_idx(input logic [3:0] code);
        if (code == CH1_CODE_DEF) return 1;
        if (code == CH2_CODE_DEF) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] code_of(input int c);
        if (c == 1) return CH1_CODE_DEF;
        if (c == 2) return CH2_CODE_DEF;
        return CH0_CODE_DEF;
    endfunction

    function automatic logic [15:0] reg_of(input logic [1:0] c);
        if (c == 2'd0) return temperature1;
        if (c == 2'd1) return temperature2;
        return foot;
    endfunction

    function automatic logic [1:0] last_ch(input logic [2:0] m);
        if (m[2]) return 2'd2;
        if (m[1]) return 2'd1;
        return 2'd0;
    endfunction

    // ADC model: busy for 3 cycles after a start, then drops the flag with data; predicts averages
    initial begin : adc_model
        int          idx;
        logic [15:0] v;
        int          k[3];
        int          sum[3];
        exp_t        e_new;
        adc_flag = 1'b0;
        adc_data = 16'h0;
        k   = '{0, 0, 0};
        sum = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                k   = '{0, 0, 0};
                sum = '{0, 0, 0};
                sb_q.delete();
            end else if (adc_start) begin
                idx = code_idx(adc_ch);
                code_log.push_back(adc_ch);
                adc_flag = 1'b1;
                repeat (3) @(negedge clk);
                if (!hang[idx]) begin
                    v = base[idx] + step * 16'(k[idx]);
                    adc_data = v;
                    adc_flag = 1'b0;
                    sum[idx] += int'(v);
                    k[idx]++;
                    if (k[idx] == NSAMP) begin
                        e_new.ch  = 2'(idx);
                        e_new.val = 16'(sum[idx] >> OSR);
                        sb_q.push_back(e_new);
                        k[idx]   = 0;
                        sum[idx] = 0;
                    end
                end
            end else if (glitch_req != glitch_done) begin
                adc_flag = 1'b1;
                repeat (4) @(negedge clk);
                adc_flag = 1'b0;
                glitch_done++;
            end
        end
    end

    // Scoreboard consumer: every published result must match the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: ch %0d value %0h with nothing pending", result_ch, reg_of(result_ch));
            end else begin
                e = sb_q.pop_front();
                check("result_ch", 32'(result_ch), 32'(e.ch));
                check("result_value", 32'(reg_of(result_ch)), 32'(e.val));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_result(input logic [1:0] ch, input int budget, output int at);
        int n = 0;
        at = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (result_valid && result_ch == ch) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_result: ch %0d not published within %0d cycles", ch, budget);
        end
    endtask

    task automatic wait_start(input logic [3:0] code, input int budget, output int at);
        int n = 0;
        at = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (adc_start) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_start: no adc_start within %0d cycles", budget);
        end else begin
            check("start_code", 32'(adc_ch), 32'(code));
        end
    endtask

    task automatic check_log(input logic [2:0] mask);
        logic [3:0] exp_q[$];
        for (int c = 0; c < 3; c++)
            if (mask[c])
                for (int s = 0; s < NSAMP; s++) exp_q.push_back(code_of(c));
        check("log_len", 32'(code_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < code_log.size(); i++)
            check("adc_ch_seq", 32'(code_log[i]), 32'(exp_q[i]));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c1, c2, at, n, starts;

        vt[0] = '{mask: 3'b111, b0: 16'd100,  b1: 16'd200, b2: 16'd300,  st: 16'd4,
                  e0: 16'd106,  e1: 16'd206,  e2: 16'd306};
        vt[1] = '{mask: 3'b101, b0: 16'd1000, b1: 16'd5,   b2: 16'd7000, st: 16'd1,
                  e0: 16'd1001, e1: 16'd206,  e2: 16'd7001};
        vt[2] = '{mask: 3'b010, b0: 16'd9,    b1: 16'd50,  b2: 16'd9,    st: 16'd3,
                  e0: 16'd1001, e1: 16'd54,   e2: 16'd7001};
        vt[3] = '{mask: 3'b111, b0: 16'hFFFF, b1: 16'hFFFF, b2: 16'hFFFF, st: 16'd0,
                  e0: 16'hFFFF, e1: 16'hFFFF, e2: 16'hFFFF};
        vt[4] = '{mask: 3'b100, b0: 16'd1,    b1: 16'd1,   b2: 16'h8000, st: 16'h1000,
                  e0: 16'hFFFF, e1: 16'hFFFF, e2: 16'h9800};

        reset_n = 1'b0;
        enable  = 1'b0;
        ch_mask = 3'b000;
        step    = 16'd0;
        for (int i = 0; i < 3; i++) begin
            base[i] = 16'd0;
            hang[i] = 1'b0;
        end

        // Reset state
        wait_cycles(3);
        check("rst_ctrl", 32'({adc_ch, adc_start, result_valid, result_ch, timeout_err}), 32'd0);
        check("rst_results", 32'({temperature1, temperature2}), 32'd0);
        check("rst_foot", 32'(foot), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        starts = 0;
        repeat (10) begin
            @(negedge clk);
            if (adc_start) starts++;
        end
        check("no_start_disabled", 32'(starts), 32'd0);

        // Table-driven full scans
        for (int i = 0; i < 5; i++) begin
            base[0] = vt[i].b0;
            base[1] = vt[i].b1;
            base[2] = vt[i].b2;
            step    = vt[i].st;
            ch_mask = vt[i].mask;
            code_log.delete();
            enable  = 1'b1;
            wait_result(last_ch(vt[i].mask), 600, at);
            enable  = 1'b0;
            wait_cycles(5);
            check("vec_temperature1", 32'(temperature1), 32'(vt[i].e0));
            check("vec_temperature2", 32'(temperature2), 32'(vt[i].e1));
            check("vec_foot", 32'(foot), 32'(vt[i].e2));
            check_log(vt[i].mask);
            check("vec_sb_empty", 32'(sb_q.size()), 32'd0);
        end

        // Scan period spacing, then enable dropped mid-conversion on CH0
        base[0] = 16'd400;
        base[2] = 16'd600;
        step    = 16'd8;
        ch_mask = 3'b101;
        code_log.delete();
        enable  = 1'b1;
        wait_result(2'd2, 600, c1);
        base[0] = 16'd800;
        wait_start(CH0_CODE_DEF, 200, c2);
        check("period_spacing", 32'(c2 - c1), 32'(SP + 1));
        @(negedge clk);
        enable = 1'b0;
        wait_result(2'd0, 200, at);
        starts = 0;
        repeat (100) begin
            @(negedge clk);
            if (adc_start) starts++;
        end
        check("no_start_after_disable", 32'(starts), 32'd0);
        check("idle_after_disable", 32'(dut.state_q), 32'(ST_IDLE));
        check("t4_temperature1", 32'(temperature1), 32'd812);
        check("t2_temperature2_kept", 32'(temperature2), 32'hFFFF);
        check("t2_foot", 32'(foot), 32'd612);
        check("t2_log_len", 32'(code_log.size()), 32'(3 * NSAMP));

        // CH1 never finishes: timeout flag, scan continues to CH2
        base[0] = 16'd10;
        base[1] = 16'd20;
        base[2] = 16'd30;
        step    = 16'd0;
        hang[1] = 1'b1;
        ch_mask = 3'b111;
        enable  = 1'b1;
        wait_start(CH0_CODE_DEF, 50, at);
        wait_result(2'd0, 300, at);
        wait_start(CH1_CODE_DEF, 50, c1);
        c2 = -1;
        n = 0;
        while (n < TMO + 20) begin
            @(negedge clk);
            n++;
            if (timeout_err != 3'b000) begin
                c2 = cyc;
                break;
            end
        end
        check("timeout_latency", 32'(c2 - c1), 32'(TMO + 1));
        wait_result(2'd2, 300, at);
        enable = 1'b0;
        wait_cycles(5);
        hang[1] = 1'b0;
        check("timeout_err", 32'(timeout_err), 32'b010);
        check("t3_temperature1", 32'(temperature1), 32'd10);
        check("t3_temperature2_kept", 32'(temperature2), 32'hFFFF);
        check("t3_foot", 32'(foot), 32'd30);

        // Full-scale data and a flag glitch during the inter-scan wait
        base[0] = 16'hFFFF;
        step    = 16'd0;
        ch_mask = 3'b001;
        enable  = 1'b1;
        wait_result(2'd0, 300, c1);
        glitch_req++;
        wait_start(CH0_CODE_DEF, 200, c2);
        check("glitch_period_spacing", 32'(c2 - c1), 32'(SP + 1));
        @(negedge clk);
        enable = 1'b0;
        wait_result(2'd0, 300, at);
        wait_cycles(5);
        check("t6_temperature1", 32'(temperature1), 32'hFFFF);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset asserted while capturing on CH1, then a fresh scan from CH0
        base[0] = 16'd1;
        base[1] = 16'd2;
        base[2] = 16'd3;
        ch_mask = 3'b111;
        enable  = 1'b1;
        n = 0;
        while (n < 600 && !(dut.state_q == ST_CAPT && dut.ch_q == 2'd1)) begin
            @(negedge clk);
            n++;
        end
        check("reached_capt_ch1", 32'(n < 600), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ctrl", 32'({adc_ch, adc_start, result_valid, result_ch, timeout_err}), 32'd0);
        check("async_rst_results", 32'({temperature1, temperature2}), 32'd0);
        check("async_rst_foot", 32'(foot), 32'd0);
        code_log.delete();
        starts = 0;
        repeat (3) begin
            @(negedge clk);
            if (adc_start) starts++;
        end
        check("no_start_in_reset", 32'(starts), 32'd0);
        reset_n = 1'b1;
        wait_result(2'd2, 600, at);
        enable = 1'b0;
        wait_cycles(5);
        check("t5_temperature1", 32'(temperature1), 32'd1);
        check("t5_temperature2", 32'(temperature2), 32'd2);
        check("t5_foot", 32'(foot), 32'd3);
        check("t5_timeout_cleared", 32'(timeout_err), 32'd0);
        check_log(3'b111);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
